mvm_accum_seq: RTL and testbench
================================

// Module: mvm_accum_seq
// PURPOSE
//   Sequencer for one matrix-vector dot-product lane of the MVM engine.
//   On start, it walks a row-major matrix: num_rows rows x num_chunks words.
//   - Issues vector and matrix memory reads.
//   - Generates the ivalid/first/last tags the accumulator consumes, delayed to
//     match the memory and multiply pipeline.
//   - Pulses done once the last accumulator result has left the datapath.
// PARAMETERS
//   DIMW      9  width of num_rows / num_chunks (max 2^DIMW-1 each)
//   VEC_ADDRW 9  vector memory read-address width
//   MAT_ADDRW 9  matrix memory read-address width
//   PIPE_LAT  3  cycles from rd_en to matching data at accumulator input (>=1)
//   ACC_LAT   2  cycles from accumulator last input to its ovalid (>=1)
// PORTS
//   clk         in   1          clock
//   rst         in   1          synchronous, active-high reset
//   start       in   1          begin a job; sampled only in IDLE
//   num_rows    in   DIMW       rows in job; latched on accepted start
//   num_chunks  in   DIMW       words per row; latched on accepted start
//   stall       in   1          downstream backpressure; blocks read issue
//   busy        out  1          high in any state other than IDLE
//   done        out  1          1-cycle pulse at job end
//   rd_en       out  1          read strobe to vector and matrix memories
//   vec_raddr   out  VEC_ADDRW  vector word index (current chunk)
//   mat_raddr   out  MAT_ADDRW  matrix word index (row*num_chunks+chunk)
//   pe_ivalid   out  1          to accumulator ivalid
//   pe_first    out  1          to accumulator first (chunk==0)
//   pe_last     out  1          to accumulator last (chunk==num_chunks-1)
// BEHAVIOUR
//   Reset: state=IDLE, all counters 0, tag pipeline cleared, all outputs 0.
//   FSM states: IDLE, RUN, DRAIN, DONE.
//   - IDLE -> RUN on start with num_rows!=0 and num_chunks!=0. Latch the
//     dimensions and clear the row, chunk and mat address counters.
//   - IDLE -> DONE on start with either dimension 0. No reads, no tags.
//   - RUN: each cycle with stall=0, assert rd_en with the current addresses and
//     push {1, chunk==0, chunk==num_chunks-1} into the tag pipeline.
//     - After each issued read: chunk++ and mat_raddr++.
//     - When chunk reaches num_chunks-1: chunk wraps to 0 and row++.
//     - The read with row==num_rows-1 and chunk==num_chunks-1 issues, then the
//       FSM moves to DRAIN.
//   - RUN with stall=1: rd_en=0, counters and addresses hold, push {0,0,0}.
//   - DRAIN: count exactly PIPE_LAT+ACC_LAT cycles, then go to DONE.
//     - stall is ignored in DRAIN.
//     - The tag pipeline always shifts; stall never freezes it.
//   - DONE: done=1 for this one cycle, then go to IDLE. start is ignored in DONE.
//   Output timing:
//   - rd_en, vec_raddr and mat_raddr are registered; the first read appears the
//     cycle after start is accepted.
//   - vec_raddr = chunk.
//   - pe_* = the tag pushed PIPE_LAT cycles earlier, registered. pe_first and
//     pe_last are 0 whenever pe_ivalid=0.
//   - With num_chunks==1, every tag has first=1 and last=1.
//   - mat_raddr wraps modulo 2^MAT_ADDRW; the block flags no error.
//   - busy=1 from the cycle after start is accepted through the DONE cycle.
//   Job latency with no stalls: N = R*C reads, where R = num_rows and
//   C = num_chunks, in cycles 1..N after the start cycle 0. done asserts at
//   cycle N+PIPE_LAT+ACC_LAT+1. Each stall cycle in RUN adds exactly 1 cycle.
//   start while busy: ignored; the latched dimensions do not change.
//   Reset mid-job: next cycle is IDLE with all outputs 0. The pipeline is
//   flushed, so no stale pe_ivalid follows reset.
// TESTING
//   1. PIPE_LAT=3, ACC_LAT=2, start at cycle 0, R=2, C=3, stall=0:
//      - rd_en in cycles 1-6; vec_raddr 0,1,2,0,1,2; mat_raddr 0..5.
//      - pe_ivalid in cycles 4-9; pe_first at 4 and 7; pe_last at 6 and 9.
//      - done at cycle 12 only; busy high in cycles 1-12.
//   2. As test 1 with stall=1 in cycles 2-3:
//      - rd_en low and addresses held in those cycles; pe_ivalid low in 5-6.
//      - done moves to cycle 14.
//   3. start with R=0, C=5, then R=5, C=0:
//      - each gives done the cycle after start; never rd_en or pe_ivalid.
//   4. R=4, C=1:
//      - four pe_ivalid cycles, each with pe_first=pe_last=1; mat_raddr 0..3.
//   5. start pulsed at cycles 3 and 12 of test 1:
//      - job unchanged; start at cycle 13 (after done) begins a new job.
//   6. rst at cycle 4 of test 1:
//      - cycle 5 has busy=0 and rd_en=0; no pe_ivalid afterward.
//      - A fresh start replays test 1 timing exactly.

Source files
------------

// File: rtl/mvm_accum_seq.sv
// Read sequencer for one MVM dot-product lane: walks a row-major matrix, issues
// vector/matrix reads and emits latency-matched accumulator tags.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing one read per unstalled cycle
// DRAIN | letting the last tag and accumulator result leave the datapath
// DONE  | one-cycle job-complete pulse
module mvm_accum_seq #(
    parameter int DIMW      = 9,
    parameter int VEC_ADDRW = 9,
    parameter int MAT_ADDRW = 9,
    parameter int PIPE_LAT  = 3,
    parameter int ACC_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIMW-1:0]      num_rows,
    input  logic [DIMW-1:0]      num_chunks,
    input  logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [VEC_ADDRW-1:0] vec_raddr,
    output logic [MAT_ADDRW-1:0] mat_raddr,
    output logic                 pe_ivalid,
    output logic                 pe_first,
    output logic                 pe_last
);
    localparam int DRAIN_CYC = PIPE_LAT + ACC_LAT;
    localparam int DCW       = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state;
    logic [DIMW-1:0]      rows_q;
    logic [DIMW-1:0]      chunks_q;
    logic [DIMW-1:0]      row;
    logic [DIMW-1:0]      chunk;
    logic [MAT_ADDRW-1:0] mat_cnt;
    logic [DCW-1:0]       drain_cnt;
    logic [2:0]           tag_pipe [PIPE_LAT];
    logic                 issue;
    logic                 chunk_last;
    logic                 row_last;

    // A read issues in any unstalled RUN cycle; the address counters hold otherwise.
    assign issue      = (state == RUN) && !stall;
    assign chunk_last = (chunk == chunks_q - DIMW'(1));
    assign row_last   = (row == rows_q - DIMW'(1));

    assign rd_en     = issue;
    assign vec_raddr = VEC_ADDRW'(chunk);
    assign mat_raddr = mat_cnt;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign pe_ivalid = tag_pipe[PIPE_LAT-1][2];
    assign pe_first  = tag_pipe[PIPE_LAT-1][1];
    assign pe_last   = tag_pipe[PIPE_LAT-1][0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rows_q    <= '0;
            chunks_q  <= '0;
            row       <= '0;
            chunk     <= '0;
            mat_cnt   <= '0;
            drain_cnt <= '0;
            for (int i = 0; i < PIPE_LAT; i++) tag_pipe[i] <= 3'b000;
        end else begin
            // The tag pipeline free-runs so tags stay aligned with memory data.
            tag_pipe[0] <= {issue, issue && (chunk == '0), issue && chunk_last};
            for (int i = 1; i < PIPE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

            case (state)
                IDLE: begin
                    if (start) begin
                        rows_q   <= num_rows;
                        chunks_q <= num_chunks;
                        row      <= '0;
                        chunk    <= '0;
                        mat_cnt  <= '0;
                        state    <= (num_rows != '0 && num_chunks != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        mat_cnt <= mat_cnt + MAT_ADDRW'(1);
                        if (chunk_last) begin
                            chunk <= '0;
                            row   <= row + DIMW'(1);
                            if (row_last) begin
                                state     <= DRAIN;
                                drain_cnt <= DCW'(DRAIN_CYC - 1);
                            end
                        end else begin
                            chunk <= chunk + DIMW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) state <= DONE;
                    else drain_cnt <= drain_cnt - DCW'(1);
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mvm_accum_seq.sv
// Bench for mvm_accum_seq: per-cycle comparison against a read-schedule model,
// table-driven jobs, randomized jobs and hand-written start/reset sequences.
module tb_mvm_accum_seq;
    localparam int PL = 3;
    localparam int AL = 2;
    localparam int MAXC = 512;

    logic       clk = 1'b0;
    logic       rst, start, stall;
    logic [8:0] num_rows, num_chunks;
    logic       busy, done, rd_en, pe_ivalid, pe_first, pe_last;
    logic [8:0] vec_raddr, mat_raddr;

    mvm_accum_seq #(.DIMW(9), .VEC_ADDRW(9), .MAT_ADDRW(9), .PIPE_LAT(PL), .ACC_LAT(AL)) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .num_chunks(num_chunks),
        .stall(stall), .busy(busy), .done(done), .rd_en(rd_en), .vec_raddr(vec_raddr),
        .mat_raddr(mat_raddr), .pe_ivalid(pe_ivalid), .pe_first(pe_first), .pe_last(pe_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        int stall_bits;
        int exp_done;
    } vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    bit stall_arr [MAXC];
    bit start_arr [MAXC];
    bit e_busy [MAXC], e_done [MAXC], e_rd [MAXC], e_run [MAXC];
    bit e_iv [MAXC], e_f [MAXC], e_l [MAXC];
    int e_vec [MAXC], e_mat [MAXC];

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %06h expected %06h", name, act, exp);
    endtask

    task automatic clear_stim();
        for (int t = 0; t < MAXC; t++) begin
            stall_arr[t] = 1'b0;
            start_arr[t] = 1'b0;
        end
    endtask

    // Read k of the job goes out on the k-th unstalled RUN cycle; its tag reaches
    // the accumulator PL cycles later; done follows the last read by PL+AL+1.
    task automatic build_model(input int r, input int c, output int dn);
        for (int t = 0; t < MAXC; t++) begin
            e_busy[t] = 0; e_done[t] = 0; e_rd[t] = 0; e_run[t] = 0;
            e_iv[t] = 0; e_f[t] = 0; e_l[t] = 0; e_vec[t] = 0; e_mat[t] = 0;
        end
        if (r == 0 || c == 0) begin
            dn = 1;
        end else begin
            int k = 0;
            int t = 1;
            while (k < r * c && t < 400) begin
                e_run[t] = 1;
                e_vec[t] = k % c;
                e_mat[t] = k % 512;
                if (!stall_arr[t]) begin
                    e_rd[t] = 1;
                    e_iv[t+PL] = 1;
                    e_f[t+PL] = (k % c == 0);
                    e_l[t+PL] = (k % c == c - 1);
                    k++;
                end
                t++;
            end
            dn = t - 1 + PL + AL + 1;
        end
        for (int t = 1; t <= dn; t++) e_busy[t] = 1;
        e_done[dn] = 1;
    endtask

    task automatic run_job(input int r, input int c, input int tbl_done, input int abort_at,
                           input string name);
        int dn;
        logic [23:0] act, exp;
        build_model(r, c, dn);
        for (int t = 0; t <= dn; t++) begin
            @(posedge clk); #1;
            if (t == 0) begin
                start = 1'b1;
                num_rows = 9'(r);
                num_chunks = 9'(c);
            end else begin
                start = start_arr[t];
                num_rows = 9'($urandom_range(1, 511));
                num_chunks = 9'($urandom_range(1, 511));
            end
            stall = stall_arr[t];
            rst = (t == abort_at);
            @(negedge clk);
            act = {busy, done, rd_en, pe_ivalid, pe_first, pe_last,
                   e_run[t] ? vec_raddr : 9'd0, e_run[t] ? mat_raddr : 9'd0};
            exp = {e_busy[t], e_done[t], e_rd[t], e_iv[t], e_f[t], e_l[t],
                   9'(e_vec[t]), 9'(e_mat[t])};
            check($sformatf("%s cyc%0d", name, t), act, exp);
            if (t == tbl_done) check($sformatf("%s done_at%0d", name, t), {23'd0, done}, 24'd1);
            if (t == abort_at) return;
        end
    endtask

    task automatic idle_cycles(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 1'b0; stall = 1'b0; rst = 1'b0;
            @(negedge clk);
            check($sformatf("%s idle%0d", name, i),
                  {20'd0, busy, done, rd_en, pe_ivalid}, 24'd0);
        end
    endtask

    vec_t tbl [7];

    initial begin
        tbl[0] = '{2, 3, 0, 12};
        tbl[1] = '{2, 3, (1 << 2) | (1 << 3), 14};
        tbl[2] = '{0, 5, 0, 1};
        tbl[3] = '{5, 0, 0, 1};
        tbl[4] = '{4, 1, 0, 10};
        tbl[5] = '{1, 1, 0, 7};
        tbl[6] = '{3, 4, (1 << 1) | (1 << 5) | (1 << 6), 21};

        rst = 1'b1; start = 1'b0; stall = 1'b0; num_rows = '0; num_chunks = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset", {busy, done, rd_en, pe_ivalid, pe_first, pe_last, vec_raddr, mat_raddr}, 24'd0);
        idle_cycles(1, "post_reset");

        for (int i = 0; i < 7; i++) begin
            int sb;
            clear_stim();
            sb = tbl[i].stall_bits;
            for (int b = 0; b < 32; b++) stall_arr[b] = sb[b];
            run_job(tbl[i].r, tbl[i].c, tbl[i].exp_done, -1, $sformatf("tbl%0d", i));
            idle_cycles(1, $sformatf("tbl%0d", i));
        end

        // start pulses while busy are ignored; a start right after done is taken
        clear_stim();
        start_arr[3] = 1'b1;
        start_arr[12] = 1'b1;
        run_job(2, 3, 12, -1, "start_busy");
        clear_stim();
        run_job(2, 3, 12, -1, "restart");
        idle_cycles(1, "restart");

        // synchronous reset mid-job flushes everything, then a clean replay
        clear_stim();
        run_job(2, 3, -1, 4, "rst_mid");
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("rst_mid after", {busy, done, rd_en, pe_ivalid, pe_first, pe_last, vec_raddr, mat_raddr}, 24'd0);
        idle_cycles(8, "rst_mid");
        clear_stim();
        run_job(2, 3, 12, -1, "replay");
        idle_cycles(1, "replay");

        for (int j = 0; j < 10; j++) begin
            int r, c;
            clear_stim();
            r = $urandom_range(0, 6);
            c = $urandom_range(0, 6);
            for (int t = 0; t < 128; t++) stall_arr[t] = ($urandom_range(0, 3) == 0);
            for (int t = 1; t < 128; t++) start_arr[t] = ($urandom_range(0, 7) == 0);
            run_job(r, c, -1, -1, $sformatf("rnd%0d r%0d c%0d", j, r, c));
            idle_cycles(1, $sformatf("rnd%0d", j));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
